// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the lc3b pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  // MEM-side sequencer state: normal run, or second access of LDI/STI
  typedef logic [0:0] lc3b_mem_ctrl_state;
  localparam lc3b_mem_ctrl_state M_RUN  = 1'b0;
  localparam lc3b_mem_ctrl_state M_IND2 = 1'b1;

  // Fetch-side sequencer state: normal run, or waiting to apply a pending redirect
  typedef logic [0:0] lc3b_fetch_ctrl_state;
  localparam lc3b_fetch_ctrl_state F_RUN   = 1'b0;
  localparam lc3b_fetch_ctrl_state F_REDIR = 1'b1;

  // One bundle holding every strobe the controller drives into the pipeline
  typedef struct packed {
    logic load_pc;
    logic pc_redirect;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_mem_wb;
  } hazard_strobes_t;

  // True when an ID source operand is actually read and names the EX destination
  function automatic logic src_match(input logic use_en, input lc3b_reg src, input lc3b_reg dest);
    return use_en && (src == dest);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller connection bundle: pipeline status in, stall/flush strobes out.
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  logic     imem_req;
  logic     imem_resp;
  logic     dmem_req;
  logic     dmem_resp;
  logic     mem_indirect;
  logic     id_ex_is_load;
  logic     id_ex_is_nop;
  lc3b_reg  id_ex_dest;
  lc3b_reg  if_id_sr1_id;
  lc3b_reg  if_id_sr2_id;
  logic     if_id_sr1_use;
  logic     if_id_sr2_use;
  logic     ex_mispredict;
  lc3b_word ex_target_pc;

  logic     load_pc;
  logic     pc_redirect;
  lc3b_word redirect_pc;
  logic     load_if_id;
  logic     load_id_ex;
  logic     load_ex_mem;
  logic     load_mem_wb;
  logic     flush_if_id;
  logic     flush_id_ex;
  logic     flush_mem_wb;
  logic     mem_ind_phase;

  // Pipeline side: reports status, consumes strobes
  modport master (
    output imem_req, imem_resp, dmem_req, dmem_resp, mem_indirect,
           id_ex_is_load, id_ex_is_nop, id_ex_dest,
           if_id_sr1_id, if_id_sr2_id, if_id_sr1_use, if_id_sr2_use,
           ex_mispredict, ex_target_pc,
    input  load_pc, pc_redirect, redirect_pc,
           load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, flush_mem_wb, mem_ind_phase
  );

  // Controller side: consumes status, drives strobes
  modport slave (
    input  imem_req, imem_resp, dmem_req, dmem_resp, mem_indirect,
           id_ex_is_load, id_ex_is_nop, id_ex_dest,
           if_id_sr1_id, if_id_sr2_id, if_id_sr1_use, if_id_sr2_use,
           ex_mispredict, ex_target_pc,
    output load_pc, pc_redirect, redirect_pc,
           load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, flush_mem_wb, mem_ind_phase
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear beats increment; the count sticks at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage lc3b pipeline.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave hz,
  input  logic                 perf_clear,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  lc3b_mem_ctrl_state   mem_state;
  lc3b_mem_ctrl_state   mem_state_next;
  lc3b_fetch_ctrl_state fetch_state;
  lc3b_fetch_ctrl_state fetch_state_next;
  lc3b_word             redirect_q;
  hazard_strobes_t      strb;

  logic mem_ind_phase;
  logic mem_stall;
  logic fetch_stall;
  logic load_use;
  logic misp_act;
  logic redirect_now;
  logic enter_redir;

  assign mem_ind_phase = (mem_state == M_IND2);
  assign mem_stall     = hz.dmem_req & (~hz.dmem_resp | (hz.mem_indirect & ~mem_ind_phase));
  assign fetch_stall   = hz.imem_req & ~hz.imem_resp;
  assign load_use      = hz.id_ex_is_load & ~hz.id_ex_is_nop &
                         (src_match(hz.if_id_sr1_use, hz.if_id_sr1_id, hz.id_ex_dest) |
                          src_match(hz.if_id_sr2_use, hz.if_id_sr2_id, hz.id_ex_dest));

  // A mispredict under a MEM stall is left alone; EX re-presents it once MEM frees up
  assign misp_act     = hz.ex_mispredict & ~mem_stall & ~reset;
  assign redirect_now = misp_act & ~fetch_stall;
  assign enter_redir  = misp_act & fetch_stall & (fetch_state == F_RUN);

  // Strobe priority: reset, MEM stall, mispredict, pending redirect, load-use, fetch stall
  always_comb begin
    strb = '{load_pc: 1'b1, pc_redirect: 1'b0,
             load_if_id: 1'b1, load_id_ex: 1'b1, load_ex_mem: 1'b1, load_mem_wb: 1'b1,
             flush_if_id: 1'b0, flush_id_ex: 1'b0, flush_mem_wb: 1'b0};
    if (reset) begin
      strb.load_pc      = 1'b0;
      strb.flush_if_id  = 1'b1;
      strb.flush_id_ex  = 1'b1;
      strb.flush_mem_wb = 1'b1;
    end else if (mem_stall) begin
      strb.load_pc      = 1'b0;
      strb.load_if_id   = 1'b0;
      strb.load_id_ex   = 1'b0;
      strb.load_ex_mem  = 1'b0;
      strb.flush_mem_wb = 1'b1;
    end else if (hz.ex_mispredict) begin
      strb.flush_if_id  = 1'b1;
      strb.flush_id_ex  = 1'b1;
      strb.load_pc      = ~fetch_stall;
      strb.pc_redirect  = ~fetch_stall;
    end else if (fetch_state == F_REDIR) begin
      strb.flush_if_id  = 1'b1;
      strb.flush_id_ex  = 1'b1;
      strb.load_pc      = hz.imem_resp;
      strb.pc_redirect  = hz.imem_resp;
    end else if (load_use) begin
      strb.load_pc      = 1'b0;
      strb.load_if_id   = 1'b0;
      strb.flush_id_ex  = 1'b1;
    end else if (fetch_stall) begin
      strb.load_pc      = 1'b0;
      strb.flush_if_id  = 1'b1;
    end
  end

  // MEM sequencer: the first LDI/STI access completing arms the second access
  always_comb begin
    mem_state_next = mem_state;
    case (mem_state)
      M_RUN:   if (hz.mem_indirect && hz.dmem_req && hz.dmem_resp) mem_state_next = M_IND2;
      M_IND2:  if (hz.dmem_resp) mem_state_next = M_RUN;
      default: mem_state_next = M_RUN;
    endcase
  end

  // Fetch sequencer: leave F_REDIR only on a cycle where the PC really takes the redirect,
  // so a MEM stall coinciding with imem_resp does not lose the pending target
  always_comb begin
    fetch_state_next = fetch_state;
    case (fetch_state)
      F_RUN:   if (enter_redir) fetch_state_next = F_REDIR;
      F_REDIR: if (hz.imem_resp && !mem_stall) fetch_state_next = F_RUN;
      default: fetch_state_next = F_RUN;
    endcase
  end

  // State registers plus the redirect target captured when the fetch is busy
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_state   <= M_RUN;
      fetch_state <= F_RUN;
      redirect_q  <= '0;
    end else begin
      mem_state   <= mem_state_next;
      fetch_state <= fetch_state_next;
      if (enter_redir) begin
        redirect_q <= hz.ex_target_pc;
      end
    end
  end

  assign hz.load_pc       = strb.load_pc;
  assign hz.pc_redirect   = strb.pc_redirect;
  assign hz.redirect_pc   = redirect_now ? hz.ex_target_pc : redirect_q;
  assign hz.load_if_id    = strb.load_if_id;
  assign hz.load_id_ex    = strb.load_id_ex;
  assign hz.load_ex_mem   = strb.load_ex_mem;
  assign hz.load_mem_wb   = strb.load_mem_wb;
  assign hz.flush_if_id   = strb.flush_if_id;
  assign hz.flush_id_ex   = strb.flush_id_ex;
  assign hz.flush_mem_wb  = strb.flush_mem_wb;
  assign hz.mem_ind_phase = mem_ind_phase;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (perf_clear),
    .inc   (~strb.load_pc & ~reset),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (perf_clear),
    .inc   (misp_act),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for the lc3b pipeline hazard controller.
module tb_pipeline_hazard_ctrl;

  // Expected strobe patterns {load_pc, pc_redirect, load_if_id, load_id_ex,
  // load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, flush_mem_wb}
  localparam logic [8:0] S_NORM  = 9'b1_0_1111_000;
  localparam logic [8:0] S_RST   = 9'b0_0_1111_111;
  localparam logic [8:0] S_MSTL  = 9'b0_0_0001_001;
  localparam logic [8:0] S_MPGO  = 9'b1_1_1111_110;
  localparam logic [8:0] S_MPWT  = 9'b0_0_1111_110;
  localparam logic [8:0] S_LUSE  = 9'b0_0_0111_010;
  localparam logic [8:0] S_FSTL  = 9'b0_0_1111_100;

  logic        clk = 1'b0;
  logic        reset;
  logic        perf_clear;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(.CNT_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .hz         (hz),
    .perf_clear (perf_clear),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ireq, iresp, dreq, dresp, ind, ld, nop;
    logic [2:0]  dest, sr1, sr2;
    logic        u1, u2, misp, clr;
    logic [15:0] tgt;
    logic [8:0]  exp_strb;
    logic        chk_regs;
    logic        exp_ph;
    logic [15:0] exp_sc, exp_fc;
    logic        rpc_care;
    logic [15:0] exp_rpc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t base(input logic [15:0] sc, input logic [15:0] fc);
    vec_t v;
    v.rst = 0; v.ireq = 0; v.iresp = 0; v.dreq = 0; v.dresp = 0; v.ind = 0;
    v.ld = 0; v.nop = 0; v.dest = 0; v.sr1 = 0; v.sr2 = 0; v.u1 = 0; v.u2 = 0;
    v.misp = 0; v.clr = 0; v.tgt = 16'h0000;
    v.exp_strb = S_NORM; v.chk_regs = 1; v.exp_ph = 0;
    v.exp_sc = sc; v.exp_fc = fc; v.rpc_care = 0; v.exp_rpc = 16'h0000;
    return v;
  endfunction

  function automatic logic [8:0] strobes();
    return {hz.load_pc, hz.pc_redirect, hz.load_if_id, hz.load_id_ex, hz.load_ex_mem,
            hz.load_mem_wb, hz.flush_if_id, hz.flush_id_ex, hz.flush_mem_wb};
  endfunction

  task automatic checkVal(input string what, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec%0d: got %0h expected %0h", what, idx, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset               = v.rst;
    perf_clear          = v.clr;
    hz.imem_req         = v.ireq;
    hz.imem_resp        = v.iresp;
    hz.dmem_req         = v.dreq;
    hz.dmem_resp        = v.dresp;
    hz.mem_indirect     = v.ind;
    hz.id_ex_is_load    = v.ld;
    hz.id_ex_is_nop     = v.nop;
    hz.id_ex_dest       = v.dest;
    hz.if_id_sr1_id     = v.sr1;
    hz.if_id_sr2_id     = v.sr2;
    hz.if_id_sr1_use    = v.u1;
    hz.if_id_sr2_use    = v.u2;
    hz.ex_mispredict    = v.misp;
    hz.ex_target_pc     = v.tgt;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    #2;
    checkVal("strobes", idx, {23'd0, strobes()}, {23'd0, v.exp_strb});
    if (v.chk_regs) begin
      checkVal("mem_ind_phase", idx, {31'd0, hz.mem_ind_phase}, {31'd0, v.exp_ph});
      checkVal("stall_cnt", idx, {16'd0, stall_cnt}, {16'd0, v.exp_sc});
      checkVal("flush_cnt", idx, {16'd0, flush_cnt}, {16'd0, v.exp_fc});
    end
    if (v.rpc_care) begin
      checkVal("redirect_pc", idx, {16'd0, hz.redirect_pc}, {16'd0, v.exp_rpc});
    end
  endtask

  initial begin
    vec_t v;

    reset = 1'b1;
    perf_clear = 1'b0;
    v = base(0, 0);
    v.rst = 1;
    applyStimulus(v);

    // Reset held for two cycles; registered state is only defined from the second
    v = base(0, 0); v.rst = 1; v.exp_strb = S_RST; v.chk_regs = 0; vecs.push_back(v);
    v = base(0, 0); v.rst = 1; v.exp_strb = S_RST; vecs.push_back(v);
    v = base(0, 0); vecs.push_back(v);

    // Load-use on sr1, then bubble / disabled-operand cases, then load-use on sr2
    v = base(0, 0); v.ld = 1; v.dest = 1; v.sr1 = 1; v.u1 = 1; v.exp_strb = S_LUSE; vecs.push_back(v);
    v = base(1, 0); vecs.push_back(v);
    v = base(1, 0); v.ld = 1; v.nop = 1; v.dest = 1; v.sr1 = 1; v.u1 = 1; vecs.push_back(v);
    v = base(1, 0); v.ld = 1; v.dest = 2; v.sr1 = 1; v.u1 = 1; v.sr2 = 2; vecs.push_back(v);
    v = base(1, 0); v.ld = 1; v.dest = 2; v.sr2 = 2; v.u2 = 1; v.exp_strb = S_LUSE; vecs.push_back(v);
    v = base(2, 0); vecs.push_back(v);

    // Plain fetch stall, then fetch completes
    v = base(2, 0); v.ireq = 1; v.exp_strb = S_FSTL; vecs.push_back(v);
    v = base(3, 0); v.ireq = 1; v.iresp = 1; vecs.push_back(v);

    // Mispredict to 3000 with fetch free: redirect same cycle
    v = base(3, 0); v.misp = 1; v.tgt = 16'h3000; v.exp_strb = S_MPGO;
    v.rpc_care = 1; v.exp_rpc = 16'h3000; vecs.push_back(v);
    v = base(3, 1); vecs.push_back(v);

    // Mispredict to 0420 while i-mem waits 4 cycles: redirect held, applied on imem_resp
    v = base(3, 1); v.misp = 1; v.tgt = 16'h0420; v.ireq = 1; v.exp_strb = S_MPWT; vecs.push_back(v);
    for (int i = 0; i < 3; i++) begin
      v = base(16'(4 + i), 2); v.ireq = 1; v.exp_strb = S_MPWT;
      v.rpc_care = 1; v.exp_rpc = 16'h0420; vecs.push_back(v);
    end
    v = base(7, 2); v.ireq = 1; v.iresp = 1; v.exp_strb = S_MPGO;
    v.rpc_care = 1; v.exp_rpc = 16'h0420; vecs.push_back(v);
    v = base(7, 2); v.rpc_care = 1; v.exp_rpc = 16'h0420; vecs.push_back(v);

    // LDI: each access answers after three wait cycles, seven frozen cycles in total
    for (int i = 0; i < 8; i++) begin
      v = base(16'(7 + i), 2); v.ind = 1; v.dreq = 1;
      v.dresp = (i == 3 || i == 7);
      v.exp_ph = (i >= 4);
      v.exp_strb = (i == 7) ? S_NORM : S_MSTL;
      vecs.push_back(v);
    end
    v = base(14, 2); vecs.push_back(v);

    // Mispredict under a MEM stall is deferred and counted once
    v = base(14, 2); v.dreq = 1; v.misp = 1; v.tgt = 16'h1234; v.exp_strb = S_MSTL; vecs.push_back(v);
    v = base(15, 2); v.dreq = 1; v.dresp = 1; v.misp = 1; v.tgt = 16'h1234; v.exp_strb = S_MPGO;
    v.rpc_care = 1; v.exp_rpc = 16'h1234; vecs.push_back(v);
    v = base(15, 3); vecs.push_back(v);

    // perf_clear wins over a stall increment in the same cycle
    v = base(15, 3); v.clr = 1; v.ireq = 1; v.exp_strb = S_FSTL; vecs.push_back(v);
    v = base(0, 0); vecs.push_back(v);

    // Reset during LDI second phase abandons it
    v = base(0, 0); v.ind = 1; v.dreq = 1; v.dresp = 1; v.exp_strb = S_MSTL; vecs.push_back(v);
    v = base(1, 0); v.rst = 1; v.ind = 1; v.dreq = 1; v.exp_strb = S_RST; v.exp_ph = 1; vecs.push_back(v);
    v = base(0, 0); vecs.push_back(v);

    // Priority: load-use over fetch stall, MEM stall over load-use
    v = base(0, 0); v.ld = 1; v.dest = 3; v.sr1 = 3; v.u1 = 1; v.ireq = 1; v.exp_strb = S_LUSE; vecs.push_back(v);
    v = base(1, 0); v.dreq = 1; v.ld = 1; v.dest = 3; v.sr1 = 3; v.u1 = 1; v.exp_strb = S_MSTL; vecs.push_back(v);
    v = base(2, 0); vecs.push_back(v);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) applyStimulus(vecs[i]);
      else begin
        @(negedge clk);
      end
      checkOutput(i, vecs[i]);
    end

    // Long forced fetch stall: stall_cnt climbs to FFFF and stays there
    v = base(0, 0); v.rst = 1;
    applyStimulus(v);
    v = base(0, 0); v.ireq = 1;
    applyStimulus(v);
    repeat (65534) @(negedge clk);
    #2;
    checkVal("stall_cnt_pre_sat", 1000, {16'd0, stall_cnt}, 32'h0000FFFE);
    @(negedge clk);
    #2;
    checkVal("stall_cnt_sat", 1001, {16'd0, stall_cnt}, 32'h0000FFFF);
    repeat (5) @(negedge clk);
    #2;
    checkVal("stall_cnt_hold", 1002, {16'd0, stall_cnt}, 32'h0000FFFF);
    checkVal("strobes_long_stall", 1003, {23'd0, strobes()}, {23'd0, S_FSTL});
    checkVal("flush_cnt_long_stall", 1004, {16'd0, flush_cnt}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
